sm4_mode_ctrl: RTL and testbench
================================

// Module: sm4_mode_ctrl
// PURPOSE
//  Sequencer in front of sm4_core. Loads key and runs key expansion, then streams
//  128-bit blocks through the core in ECB or CBC mode, with valid/ready on both sides.
//  Owns all sm4_core control pins: en_sm4, encdec, en_key_exps, key/key_valid, bdi/bdi_valid.
//  One block in flight at a time; no overlap of input and output phases.
// PARAMETERS
//  TIMEOUT  1023  max cycles waiting on key_exps_done or bdo_valid before err
//  CNT_W    32    width of blk_cnt
// PORTS
//  clk              in   1    clock; all logic on rising edge
//  rst              in   1    reset, asynchronous, active-low
//  cfg_start        in   1    1-cycle pulse: latch cfg_*, start key expansion
//  cfg_key          in   128  SM4 key
//  cfg_iv           in   128  CBC initial vector
//  cfg_mode         in   1    0=ECB, 1=CBC
//  cfg_encdec       in   1    1=encrypt, 0=decrypt
//  key_ready        out  1    expansion done, blocks accepted
//  err              out  1    sticky timeout flag; cleared by cfg_start
//  blk_cnt          out  CNT_W  blocks delivered since last cfg_start
//  s_data/s_valid   in   128/1  input block stream
//  s_ready          out  1
//  m_data/m_valid   out  128/1  output block stream
//  m_ready          in   1
//  core_en_sm4, core_encdec, core_en_key_exps, core_key_valid  out 1 each
//  core_key         out  128
//  core_bdi         out  128;  core_bdi_valid out 1
//  core_key_exps_done in 1;  core_bdo in 128;  core_bdo_valid in 1
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; every output 0; iv, ct_hold, blk_cnt, timer = 0.
//  States IDLE, KEXP, READY, BUSY, OUT; all outputs registered.
//  IDLE: s_ready=0, key_ready=0. cfg_start -> latch key/iv/mode/encdec, err<=0,
//   blk_cnt<=0, timer<=0 -> KEXP.
//  KEXP: core_en_sm4=1, core_en_key_exps=1, core_key_valid=1, core_key=latched key.
//   core_key_exps_done=1 -> drop en_key_exps/key_valid, key_ready<=1 -> READY.
//   timer==TIMEOUT -> err<=1, all core pins 0 -> IDLE.
//  READY: s_ready=1. On s_valid&&s_ready: core_bdi <= ECB: s_data; CBC enc: s_data^iv;
//   CBC dec: s_data. ct_hold<=s_data. core_bdi_valid<=1, timer<=0 -> BUSY.
//   cfg_start in READY: full re-key as from IDLE (key_ready<=0, iv reloaded).
//  BUSY: s_ready=0; core_bdi/core_bdi_valid held until core_bdo_valid=1, then:
//   m_data <= ECB: bdo; CBC enc: bdo (iv<=bdo); CBC dec: bdo^iv (iv<=ct_hold).
//   core_bdi_valid<=0, m_valid<=1 -> OUT. timer==TIMEOUT -> err<=1, core_bdi_valid<=0,
//   key_ready<=0 -> IDLE (block dropped).
//  OUT: m_data/m_valid stable while !m_ready. m_valid&&m_ready -> m_valid<=0,
//   blk_cnt<=blk_cnt+1 (wraps at 2^CNT_W) -> READY.
//  Latency: s handshake at cycle N -> core_bdi_valid=1 at N+1; core_bdo_valid sampled at
//   cycle M -> m_valid=1 at M+1. Min back-to-back: next s_ready the cycle after m handshake.
//  Ignored: cfg_start in KEXP/BUSY/OUT; core_key_exps_done outside KEXP;
//   core_bdo_valid outside BUSY; s_valid when s_ready=0.
//  core_encdec driven from latched cfg_encdec; constant between cfg_start pulses.
//  core_en_sm4=1 in every state except IDLE.
// TESTING
//  ECB enc: key=pt=0123456789abcdeffedcba9876543210 -> m_data=681edf34d206965e86b3e94f536e4246,
//   blk_cnt=1.
//  ECB dec: same key, s_data=681edf34...4246 -> m_data=0123456789abcdeffedcba9876543210.
//  CBC enc iv=0: block1 pt=0123..3210 -> 681e..4246; block2 pt=681e..4246 -> core_bdi=0.
//  CBC dec round-trip of the two CBC ciphertexts, iv=0 -> original two plaintexts; blk_cnt=2.
//  Backpressure: m_ready=0 for 20 cycles -> m_data stable, s_ready=0 throughout.
//  Core never asserts key_exps_done -> err=1 after TIMEOUT cycles, IDLE; rst=0 mid-BUSY ->
//   all outputs 0 immediately.

Source files
------------

// File: rtl/sm4_mode_ctrl_if.sv
// Bundles the config, stream and sm4_core-facing signals of sm4_mode_ctrl.
// The controller uses the slave view; the environment driving it uses the master view.
interface sm4_mode_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             cfg_start;
  logic [127:0]     cfg_key;
  logic [127:0]     cfg_iv;
  logic             cfg_mode;
  logic             cfg_encdec;
  logic             key_ready;
  logic             err;
  logic [CNT_W-1:0] blk_cnt;
  logic [127:0]     s_data;
  logic             s_valid;
  logic             s_ready;
  logic [127:0]     m_data;
  logic             m_valid;
  logic             m_ready;
  logic             core_en_sm4;
  logic             core_encdec;
  logic             core_en_key_exps;
  logic             core_key_valid;
  logic [127:0]     core_key;
  logic [127:0]     core_bdi;
  logic             core_bdi_valid;
  logic             core_key_exps_done;
  logic [127:0]     core_bdo;
  logic             core_bdo_valid;

  modport slave (
    input  cfg_start, cfg_key, cfg_iv, cfg_mode, cfg_encdec,
    input  s_data, s_valid, m_ready,
    input  core_key_exps_done, core_bdo, core_bdo_valid,
    output key_ready, err, blk_cnt, s_ready, m_data, m_valid,
    output core_en_sm4, core_encdec, core_en_key_exps, core_key_valid,
    output core_key, core_bdi, core_bdi_valid
  );

  modport master (
    output cfg_start, cfg_key, cfg_iv, cfg_mode, cfg_encdec,
    output s_data, s_valid, m_ready,
    output core_key_exps_done, core_bdo, core_bdo_valid,
    input  key_ready, err, blk_cnt, s_ready, m_data, m_valid,
    input  core_en_sm4, core_encdec, core_en_key_exps, core_key_valid,
    input  core_key, core_bdi, core_bdi_valid
  );
endinterface

// File: rtl/sm4_mode_ctrl.sv
// ECB/CBC sequencer in front of sm4_core: key expansion, then one block in flight
// at a time between the s_* input stream and the m_* output stream.
module sm4_mode_ctrl #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 32
) (
  input logic            clk,
  input logic            rst,
  sm4_mode_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, KEXP, READY, BUSY, OUT} state_e;

  state_e           state_q, state_d;
  logic [127:0]     key_q, key_d, iv_q, iv_d, ct_hold_q, ct_hold_d;
  logic [127:0]     bdi_q, bdi_d, m_data_q, m_data_d;
  logic             mode_q, mode_d, encdec_q, encdec_d, err_q, err_d;
  logic             bdi_valid_q, bdi_valid_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             s_ready_q, s_ready_d, key_ready_q, key_ready_d, m_valid_q, m_valid_d;
  logic             en_sm4_q, en_sm4_d, en_kexp_q, en_kexp_d;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    iv_d        = iv_q;
    ct_hold_d   = ct_hold_q;
    bdi_d       = bdi_q;
    m_data_d    = m_data_q;
    mode_d      = mode_q;
    encdec_d    = encdec_q;
    err_d       = err_q;
    bdi_valid_d = bdi_valid_q;
    timer_d     = timer_q;
    blk_cnt_d   = blk_cnt_q;
    if (bus.cfg_start && (state_q == IDLE || state_q == READY)) begin
      key_d     = bus.cfg_key;
      iv_d      = bus.cfg_iv;
      mode_d    = bus.cfg_mode;
      encdec_d  = bus.cfg_encdec;
      err_d     = 1'b0;
      blk_cnt_d = '0;
      timer_d   = '0;
      state_d   = KEXP;
    end else begin
      unique case (state_q)
        KEXP: begin
          if (bus.core_key_exps_done) state_d = READY;
          else if (timer_q == TMAX) begin
            // expansion never finished: release every core pin
            err_d    = 1'b1;
            key_d    = '0;
            encdec_d = 1'b0;
            state_d  = IDLE;
          end else timer_d = timer_q + TW'(1);
        end
        READY: begin
          if (bus.s_valid && s_ready_q) begin
            bdi_d       = (mode_q && encdec_q) ? (bus.s_data ^ iv_q) : bus.s_data;
            ct_hold_d   = bus.s_data;
            bdi_valid_d = 1'b1;
            timer_d     = '0;
            state_d     = BUSY;
          end
        end
        BUSY: begin
          if (bus.core_bdo_valid) begin
            if (!mode_q) m_data_d = bus.core_bdo;
            else if (encdec_q) begin
              m_data_d = bus.core_bdo;
              iv_d     = bus.core_bdo;
            end else begin
              m_data_d = bus.core_bdo ^ iv_q;
              iv_d     = ct_hold_q;
            end
            bdi_valid_d = 1'b0;
            state_d     = OUT;
          end else if (timer_q == TMAX) begin
            err_d       = 1'b1;
            bdi_valid_d = 1'b0;
            state_d     = IDLE;
          end else timer_d = timer_q + TW'(1);
        end
        OUT: begin
          if (bus.m_ready) begin
            blk_cnt_d = blk_cnt_q + CNT_W'(1);
            state_d   = READY;
          end
        end
        default: ;
      endcase
    end
    // status/enable pins are pure functions of the next state, kept registered
    s_ready_d   = (state_d == READY);
    key_ready_d = (state_d == READY) || (state_d == BUSY) || (state_d == OUT);
    m_valid_d   = (state_d == OUT);
    en_sm4_d    = (state_d != IDLE);
    en_kexp_d   = (state_d == KEXP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      iv_q        <= '0;
      ct_hold_q   <= '0;
      bdi_q       <= '0;
      m_data_q    <= '0;
      mode_q      <= 1'b0;
      encdec_q    <= 1'b0;
      err_q       <= 1'b0;
      bdi_valid_q <= 1'b0;
      timer_q     <= '0;
      blk_cnt_q   <= '0;
      s_ready_q   <= 1'b0;
      key_ready_q <= 1'b0;
      m_valid_q   <= 1'b0;
      en_sm4_q    <= 1'b0;
      en_kexp_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      iv_q        <= iv_d;
      ct_hold_q   <= ct_hold_d;
      bdi_q       <= bdi_d;
      m_data_q    <= m_data_d;
      mode_q      <= mode_d;
      encdec_q    <= encdec_d;
      err_q       <= err_d;
      bdi_valid_q <= bdi_valid_d;
      timer_q     <= timer_d;
      blk_cnt_q   <= blk_cnt_d;
      s_ready_q   <= s_ready_d;
      key_ready_q <= key_ready_d;
      m_valid_q   <= m_valid_d;
      en_sm4_q    <= en_sm4_d;
      en_kexp_q   <= en_kexp_d;
    end
  end

  assign bus.key_ready        = key_ready_q;
  assign bus.err              = err_q;
  assign bus.blk_cnt          = blk_cnt_q;
  assign bus.s_ready          = s_ready_q;
  assign bus.m_data           = m_data_q;
  assign bus.m_valid          = m_valid_q;
  assign bus.core_en_sm4      = en_sm4_q;
  assign bus.core_encdec      = encdec_q;
  assign bus.core_en_key_exps = en_kexp_q;
  assign bus.core_key_valid   = en_kexp_q;
  assign bus.core_key         = key_q;
  assign bus.core_bdi         = bdi_q;
  assign bus.core_bdi_valid   = bdi_valid_q;
endmodule

// File: tb/tb_sm4_mode_ctrl.sv
// Randomized bench for sm4_mode_ctrl: behavioural sm4_core stand-in with a real SM4
// cipher, plus an ECB/CBC reference model that predicts every output block.
module tb_sm4_mode_ctrl;
  localparam int TO = 60;
  localparam logic [127:0] K = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};

  logic clk, rst;
  int n_chk = 0, n_pass = 0;
  bit kalive = 1, balive = 1, noise = 0;
  logic [127:0] ckey = '0;
  logic [127:0] m_key, m_iv;
  bit m_mode, m_enc;
  int m_cnt;

  sm4_mode_ctrl_if #(.CNT_W(32)) bus ();
  sm4_mode_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial begin #3_000_000; $display("FAIL watchdog expired"); $fatal(1); end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tsub(input logic [31:0] a);
    logic [31:0] b;
    int idx;
    for (int i = 0; i < 4; i++) begin
      idx = int'(a[8*i +: 8]);
      b[8*i +: 8] = SBOX[2047 - 8*idx -: 8];
    end
    return b;
  endfunction

  function automatic logic [127:0] sm4(input logic [127:0] key, input logic [127:0] din, input bit enc);
    logic [31:0] k [36];
    logic [31:0] x [36];
    logic [31:0] rk [32];
    logic [31:0] ck, t;
    k[0] = key[127:96] ^ 32'ha3b1bac6; k[1] = key[95:64] ^ 32'h56aa3350;
    k[2] = key[63:32]  ^ 32'h677d9197; k[3] = key[31:0]  ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'((4*i + j) * 7);
      t = tsub(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ t ^ rol(t, 13) ^ rol(t, 23);
      rk[i] = k[i+4];
    end
    x[0] = din[127:96]; x[1] = din[95:64]; x[2] = din[63:32]; x[3] = din[31:0];
    for (int i = 0; i < 32; i++) begin
      t = tsub(x[i+1] ^ x[i+2] ^ x[i+3] ^ (enc ? rk[i] : rk[31-i]));
      x[i+4] = x[i] ^ t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  // sm4_core stand-in: random latencies, optional stray pulses when nothing is pending
  initial begin
    int kcnt, klat, bcnt, blat;
    kcnt = 0; klat = 3; bcnt = 0; blat = 2;
    bus.core_key_exps_done = 1'b0; bus.core_bdo_valid = 1'b0; bus.core_bdo = '0;
    forever begin
      @(negedge clk);
      bus.core_key_exps_done = 1'b0;
      bus.core_bdo_valid = 1'b0;
      if (bus.core_en_key_exps && bus.core_key_valid) begin
        ckey = bus.core_key;
        kcnt++;
        if (kalive && kcnt >= klat) begin
          bus.core_key_exps_done = 1'b1; kcnt = 0; klat = $urandom_range(1, 8);
        end
      end else begin
        kcnt = 0;
        if (noise && $urandom_range(0, 3) == 0) bus.core_key_exps_done = 1'b1;
      end
      if (bus.core_bdi_valid) begin
        bcnt++;
        if (balive && bcnt == blat) begin
          bus.core_bdo = sm4(ckey, bus.core_bdi, bus.core_encdec);
          bus.core_bdo_valid = 1'b1;
        end
      end else begin
        bcnt = 0; blat = $urandom_range(1, 6);
        if (noise && $urandom_range(0, 3) == 0) begin
          bus.core_bdo_valid = 1'b1; bus.core_bdo = rnd128();
        end
      end
    end
  end

  // mode reference: what the core should see and what the stream should return
  task automatic model_step(input logic [127:0] d, output logic [127:0] bdi, output logic [127:0] out);
    if (!m_mode) begin
      bdi = d; out = sm4(m_key, d, m_enc);
    end else if (m_enc) begin
      bdi = d ^ m_iv; out = sm4(m_key, bdi, 1'b1); m_iv = out;
    end else begin
      bdi = d; out = sm4(m_key, d, 1'b0) ^ m_iv; m_iv = d;
    end
  endtask

  task automatic configure(input logic [127:0] key, input logic [127:0] iv, input bit mode, input bit enc);
    int t;
    bus.cfg_key = key; bus.cfg_iv = iv; bus.cfg_mode = mode; bus.cfg_encdec = enc;
    bus.cfg_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    m_key = key; m_iv = iv; m_mode = mode; m_enc = enc; m_cnt = 0;
    chk("cfg_pins", {bus.core_en_sm4, bus.core_en_key_exps, bus.core_key_valid, bus.key_ready, bus.err},
        5'b11100);
    chk("cfg_key", bus.core_key, key);
    chk("cfg_cnt", bus.blk_cnt, 0);
    chk("cfg_encdec", bus.core_encdec, enc);
    t = 0;
    while (!bus.key_ready && t < TO + 10) begin @(negedge clk); t++; end
    chk("key_ready", {bus.key_ready, bus.s_ready, bus.core_en_key_exps}, 3'b110);
  endtask

  task automatic xfer(input logic [127:0] d, input int hold, input bit junk,
                      output logic [127:0] got_bdi, output logic [127:0] got_m);
    logic [127:0] e_bdi, e_out, held;
    int t;
    bit bad;
    t = 0;
    while (!bus.s_ready && t < 50) begin @(negedge clk); t++; end
    chk("s_ready_up", bus.s_ready, 1);
    model_step(d, e_bdi, e_out);
    bus.s_valid = 1'b1; bus.s_data = d;
    @(negedge clk);
    got_bdi = bus.core_bdi;
    chk("bdi_valid", bus.core_bdi_valid, 1);
    chk("core_bdi", bus.core_bdi, e_bdi);
    // stray traffic while busy must be ignored
    bus.s_valid = junk; bus.s_data = rnd128();
    if (junk) begin bus.cfg_start = 1'b1; bus.cfg_key = ~m_key; bus.cfg_mode = ~m_mode; end
    bad = 0; t = 0;
    while (!bus.m_valid && t < TO + 10) begin
      if (bus.s_ready) bad = 1;
      @(negedge clk);
      bus.cfg_start = 1'b0;
      t++;
    end
    bus.cfg_start = 1'b0;
    bus.s_valid = 1'b0;
    chk("m_valid_up", bus.m_valid, 1);
    chk("s_ready_busy", bad, 0);
    got_m = bus.m_data;
    chk("m_data", bus.m_data, e_out);
    held = bus.m_data; bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (bus.m_data !== held || !bus.m_valid || bus.s_ready) bad = 1;
    end
    if (hold > 0) chk("m_hold", bad, 0);
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    m_cnt++;
    chk("m_valid_drop", bus.m_valid, 0);
    chk("s_ready_b2b", bus.s_ready, 1);
    chk("blk_cnt", bus.blk_cnt, 128'(m_cnt));
  endtask

  initial begin
    logic [127:0] b, m, c1, c2;
    int t;
    rst = 1'b0;
    bus.cfg_start = 1'b0; bus.cfg_key = '0; bus.cfg_iv = '0; bus.cfg_mode = 1'b0; bus.cfg_encdec = 1'b0;
    bus.s_data = '0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {bus.s_ready, bus.key_ready, bus.err, bus.m_valid, bus.core_en_sm4,
        bus.core_encdec, bus.core_en_key_exps, bus.core_key_valid, bus.core_bdi_valid}, 0);
    chk("rst_cnt", bus.blk_cnt, 0);
    chk("rst_data", bus.m_data | bus.core_key | bus.core_bdi, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("kat_enc", sm4(K, K, 1'b1), C);
    chk("kat_dec", sm4(K, C, 1'b0), K);

    configure(K, '0, 1'b0, 1'b1);
    xfer(K, 0, 0, b, m);
    chk("ecb_enc", m, C);
    chk("ecb_cnt", bus.blk_cnt, 1);
    configure(K, '0, 1'b0, 1'b0);
    xfer(C, 1, 0, b, m);
    chk("ecb_dec", m, K);

    configure(K, '0, 1'b1, 1'b1);
    xfer(K, 0, 0, b, c1);
    chk("cbc_enc1", c1, C);
    xfer(C, 2, 0, b, c2);
    chk("cbc_bdi0", b, 0);
    configure(K, '0, 1'b1, 1'b0);
    xfer(c1, 0, 0, b, m);
    chk("cbc_dec1", m, K);
    xfer(c2, 0, 0, b, m);
    chk("cbc_dec2", m, C);
    chk("cbc_cnt", bus.blk_cnt, 2);
    xfer(rnd128(), 20, 1, b, m);

    noise = 1;
    repeat (6) begin
      configure(rnd128(), rnd128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat (5) xfer(rnd128(), $urandom_range(0, 3), 1'($urandom_range(0, 1)), b, m);
    end
    noise = 0;

    // key expansion never completes
    kalive = 0;
    bus.cfg_key = rnd128(); bus.cfg_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    repeat (TO / 2) @(negedge clk);
    chk("kexp_err_early", bus.err, 0);
    t = 0;
    while (!bus.err && t < TO + 10) begin @(negedge clk); t++; end
    chk("kexp_timeout", {bus.err, bus.key_ready, bus.s_ready, bus.core_en_sm4, bus.core_en_key_exps,
        bus.core_key_valid}, 6'b100000);
    kalive = 1;

    // core never returns a block
    configure(K, '0, 1'b0, 1'b1);
    chk("err_cleared", bus.err, 0);
    balive = 0;
    bus.s_valid = 1'b1; bus.s_data = K;
    @(negedge clk);
    bus.s_valid = 1'b0;
    t = 0;
    while (!bus.err && t < TO + 10) begin @(negedge clk); t++; end
    chk("busy_timeout", {bus.err, bus.key_ready, bus.core_bdi_valid, bus.m_valid, bus.core_en_sm4,
        bus.s_ready}, 6'b100000);
    balive = 1;

    // asynchronous reset while a block is in flight
    configure(K, '0, 1'b1, 1'b1);
    balive = 0;
    bus.s_valid = 1'b1; bus.s_data = K;
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", bus.core_bdi_valid, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_flags", {bus.s_ready, bus.key_ready, bus.err, bus.m_valid, bus.core_en_sm4,
        bus.core_encdec, bus.core_en_key_exps, bus.core_key_valid, bus.core_bdi_valid}, 0);
    chk("async_rst_data", bus.m_data | bus.core_key | bus.core_bdi | 128'(bus.blk_cnt), 0);
    @(negedge clk);
    rst = 1'b1; balive = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
